// File: rtl/branch_flow_ctrl.sv
// Branch/flow sequencing controller for the PC unit.
// - 2-bit saturating BHT supplies the prediction for the ID branch.
// - The BHT is trained when a branch resolves in MEM.
// - On a mispredict or jump: one registered redirect, then a FLUSH_LEN-cycle flush.
// - Load-use stalls are arbitrated against the flush through the bubble code.
// Optional: define BRANCH_PERF_CNT_EN to add the br_count/mis_count performance counters.
module branch_flow_ctrl #(
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned FLUSH_LEN = 3,
  parameter logic [1:0]  CTR_INIT  = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_id,
  input  logic        branch_id,
  output logic        predict,
  input  logic        br_valid_mem,
  input  logic [31:0] pc_mem,
  input  logic        taken_mem,
  input  logic        pred_mem,
  input  logic [31:0] target_mem,
  input  logic        jump_mem,
  input  logic [31:0] jump_pc_mem,
  input  logic        stall_req,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [1:0]  bubble
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] mis_count
`endif
);

  localparam int unsigned Entries = 1 << IDX_W;

  typedef enum logic {StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              redirect_q, redirect_d;
  logic [31:0]       rpc_q, rpc_d;
  logic [1:0]        bht_q [Entries];

  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic              in_run, train, mis;
  logic [31:0]       next_pc;
  logic [1:0]        ctr_old, ctr_new;
  logic              unused_pc_id;

  assign rd_idx       = pc_id[IDX_W+1:2];
  assign wr_idx       = pc_mem[IDX_W+1:2];
  assign unused_pc_id = ^{pc_id[31:IDX_W+2], pc_id[1:0]};

  // Events from MEM are only meaningful in RUN; in FLUSH they belong to squashed instructions.
  assign in_run = (state_q == StRun);
  assign train  = in_run & br_valid_mem;
  assign mis    = in_run & ((br_valid_mem & (taken_mem != pred_mem)) | jump_mem);

  // Prediction reads the pre-update counter; no write-to-read bypass.
  assign predict = branch_id & bht_q[rd_idx][1];

  // Redirect target selection, jumps taking priority over branches.
  always_comb begin
    next_pc = pc_mem + 32'd4;
    if (jump_mem) begin
      next_pc = jump_pc_mem;
    end else if (taken_mem) begin
      next_pc = target_mem;
    end
  end

  // Saturating counter update for the resolving branch.
  always_comb begin
    ctr_old = bht_q[wr_idx];
    ctr_new = ctr_old;
    if (taken_mem) begin
      if (ctr_old != 2'b11) ctr_new = ctr_old + 2'b01;
    end else begin
      if (ctr_old != 2'b00) ctr_new = ctr_old - 2'b01;
    end
  end

  // Next-state logic: RUN -> FLUSH on mis, FLUSH counts down to RUN.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    rpc_d      = rpc_q;
    unique case (state_q)
      StRun: begin
        if (mis) begin
          state_d    = StFlush;
          cnt_d      = 3'(FLUSH_LEN);
          redirect_d = 1'b1;
          rpc_d      = next_pc;
        end
      end
      StFlush: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // FSM, flush counter and redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      cnt_q      <= 3'd0;
      redirect_q <= 1'b0;
      rpc_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
      rpc_q      <= rpc_d;
    end
  end

  // Branch history table storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Entries); i++) bht_q[i] <= CTR_INIT;
    end else if (train) begin
      bht_q[wr_idx] <= ctr_new;
    end
  end

  // Outputs: flush wins over a stall; bubble 11 is never produced.
  always_comb begin
    redirect    = redirect_q;
    redirect_pc = rpc_q;
    flush       = (state_q == StFlush);
    bubble      = 2'b00;
    if (flush) begin
      bubble = 2'b10;
    end else if (stall_req) begin
      bubble = 2'b01;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] br_cnt_q, mis_cnt_q;

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else begin
      if (train) br_cnt_q <= br_cnt_q + 32'd1;
      if (mis)   mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign br_count  = br_cnt_q;
  assign mis_count = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_flow_ctrl.sv
// Scoreboard bench for branch_flow_ctrl: directed scenarios then random traffic,
// compared against a behavioural model of the prediction/flush rules.
module tb_branch_flow_ctrl;

  localparam int FLUSH_LEN = 3;
  localparam int CTR_INIT  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_id, pc_mem, target_mem, jump_pc_mem;
  logic        branch_id, br_valid_mem, taken_mem, pred_mem, jump_mem, stall_req;
  logic        predict, redirect, flush;
  logic [31:0] redirect_pc;
  logic [1:0]  bubble;
  logic [31:0] br_count, mis_count;

  always #5 clk = ~clk;

  branch_flow_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_id        (pc_id),
    .branch_id    (branch_id),
    .predict      (predict),
    .br_valid_mem (br_valid_mem),
    .pc_mem       (pc_mem),
    .taken_mem    (taken_mem),
    .pred_mem     (pred_mem),
    .target_mem   (target_mem),
    .jump_mem     (jump_mem),
    .jump_pc_mem  (jump_pc_mem),
    .stall_req    (stall_req),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .flush        (flush),
`ifdef BRANCH_PERF_CNT_EN
    .br_count     (br_count),
    .mis_count    (mis_count),
`endif
    .bubble       (bubble)
  );

`ifndef BRANCH_PERF_CNT_EN
  assign br_count  = 32'd0;
  assign mis_count = 32'd0;
`endif

  typedef struct {
    logic        predict;
    logic        redirect;
    logic [31:0] rpc;
    logic        flush;
    logic [1:0]  bubble;
    logic [31:0] brc;
    logic [31:0] misc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: counter values per table entry, cycles of flush remaining.
  int          m_bht[64];
  int          m_left;
  bit          m_first;
  logic [31:0] m_rpc, m_brc, m_misc;

  function automatic int idx_of(logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  task automatic model_reset();
    foreach (m_bht[i]) m_bht[i] = CTR_INIT;
    m_left  = 0;
    m_first = 0;
    m_rpc   = 32'd0;
    m_brc   = 32'd0;
    m_misc  = 32'd0;
  endtask

  task automatic push_expect();
    exp_t e;
    e.predict  = branch_id && (m_bht[idx_of(pc_id)] >= 2);
    e.redirect = m_first;
    e.rpc      = m_rpc;
    e.flush    = (m_left > 0);
    e.bubble   = (m_left > 0) ? 2'd2 : (stall_req ? 2'd1 : 2'd0);
    e.brc      = m_brc;
    e.misc     = m_misc;
    sb.push_back(e);
  endtask

  task automatic model_edge();
    bit mis;
    if (m_left > 0) begin
      m_left--;
      m_first = 0;
    end else begin
      m_first = 0;
      if (br_valid_mem) begin
        m_brc++;
        if (taken_mem) m_bht[idx_of(pc_mem)] = (m_bht[idx_of(pc_mem)] == 3) ? 3 : m_bht[idx_of(pc_mem)] + 1;
        else           m_bht[idx_of(pc_mem)] = (m_bht[idx_of(pc_mem)] == 0) ? 0 : m_bht[idx_of(pc_mem)] - 1;
      end
      mis = (br_valid_mem && (taken_mem != pred_mem)) || jump_mem;
      if (mis) begin
        m_misc++;
        m_left  = FLUSH_LEN;
        m_first = 1;
        if (jump_mem)       m_rpc = jump_pc_mem;
        else if (taken_mem) m_rpc = target_mem;
        else                m_rpc = pc_mem + 32'd4;
      end
    end
  endtask

  task automatic idle();
    pc_id = 32'd0; branch_id = 0; br_valid_mem = 0; pc_mem = 32'd0; taken_mem = 0;
    pred_mem = 0; target_mem = 32'd0; jump_mem = 0; jump_pc_mem = 32'd0; stall_req = 0;
  endtask

  // One cycle: record expectation for the current inputs, then advance the model at the edge.
  task automatic step();
    push_expect();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Async reset applied away from the clock edge; outputs are expected to clear at once.
  task automatic async_reset_now();
    rst_n = 1'b0;
    #1;
    model_reset();
    push_expect();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT cycle presents a full output set; compare against the queue head.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("predict", {31'd0, predict}, {31'd0, mon_e.predict});
      chk("redirect", {31'd0, redirect}, {31'd0, mon_e.redirect});
      chk("redirect_pc", redirect_pc, mon_e.rpc);
      chk("flush", {31'd0, flush}, {31'd0, mon_e.flush});
      chk("bubble", {30'd0, bubble}, {30'd0, mon_e.bubble});
`ifdef BRANCH_PERF_CNT_EN
      chk("br_count", br_count, mon_e.brc);
      chk("mis_count", mis_count, mon_e.misc);
`endif
    end
  end

  initial begin
    idle();
    model_reset();
    #1;
    async_reset_now();

    // Prediction from a fresh counter, then two taken trainings at 0x40.
    branch_id = 1; pc_id = 32'h40;
    step();
    br_valid_mem = 1; pc_mem = 32'h40; taken_mem = 1; pred_mem = 1;
    step(); step();
    br_valid_mem = 0;
    step();

    // Saturation at the same entry, then two not-taken trainings.
    br_valid_mem = 1; taken_mem = 1; pred_mem = 1;
    repeat (5) step();
    taken_mem = 0; pred_mem = 0;
    step();
    br_valid_mem = 0;
    step();
    br_valid_mem = 1;
    step();
    br_valid_mem = 0;
    step();

    // Not-taken mispredict at 0x100.
    idle();
    br_valid_mem = 1; pc_mem = 32'h100; pred_mem = 1; taken_mem = 0;
    step();
    idle();
    repeat (5) step();

    // Jump coinciding with a correctly predicted branch; stall during the flush.
    br_valid_mem = 1; pc_mem = 32'h200; taken_mem = 1; pred_mem = 1; target_mem = 32'h300;
    jump_mem = 1; jump_pc_mem = 32'h2000;
    step();
    idle();
    stall_req = 1;
    repeat (5) step();

    // Stall in RUN, then mispredict with stall in the same cycle, reset mid-flush.
    step();
    br_valid_mem = 1; pc_mem = 32'h80; taken_mem = 1; pred_mem = 0; target_mem = 32'h500;
    step();
    idle();
    step();
    async_reset_now();
    branch_id = 1; pc_id = 32'h40;
    step();

    // Fall-through wrap at the top of the address space.
    idle();
    br_valid_mem = 1; pc_mem = 32'hFFFF_FFFC; taken_mem = 0; pred_mem = 1;
    step();
    idle();
    repeat (5) step();

    // Random traffic over a small set of aliasing PCs.
    for (int n = 0; n < 600; n++) begin
      branch_id    = ($urandom_range(0, 1) == 1);
      pc_id        = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
      br_valid_mem = ($urandom_range(0, 2) == 0);
      pc_mem       = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                                  : 32'h1000 + (32'($urandom_range(0, 7)) << 2);
      taken_mem    = ($urandom_range(0, 1) == 1);
      pred_mem     = ($urandom_range(0, 3) != 0) ? taken_mem : !taken_mem;
      target_mem   = $urandom;
      jump_mem     = ($urandom_range(0, 9) == 0);
      jump_pc_mem  = $urandom;
      stall_req    = ($urandom_range(0, 3) == 0);
      step();
      if ($urandom_range(0, 199) == 0) async_reset_now();
    end
    idle();
    step();

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
